// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// Module      : pipeline_stall_ctrl
// Description : Pipeline-register control. It turns hazard stalls, taken
//               branches and HALT into PC/IF-ID/ID-EX controls, and it keeps
//               a saturating count of the cycles frozen by hazards.
//               Optional feature macro: BRANCH_DELAY_SLOT_EN (no branch flush).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
    parameter int LD_BR_STALLS = 2,
    parameter int NB_STALL_CNT = 2,
    parameter int NB_PERF_CNT  = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_hazard,
    input  logic                   i_hazard_ld_br,
    input  logic                   i_branch_taken,
    input  logic                   i_halt,
    output logic                   o_pc_we,
    output logic                   o_ifid_we,
    output logic                   o_ifid_flush,
    output logic                   o_idex_bubble,
    output logic                   o_halted,
    output logic [NB_PERF_CNT-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } state_t;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FLUSH_ON_BRANCH = 1'b0;
`else
    localparam logic FLUSH_ON_BRANCH = 1'b1;
`endif

    localparam logic [NB_STALL_CNT-1:0] REM_LOAD = NB_STALL_CNT'(LD_BR_STALLS - 1);
    localparam logic [NB_STALL_CNT-1:0] REM_ONE  = NB_STALL_CNT'(1);
    localparam logic                    MULTI_CYCLE_LD_BR = (LD_BR_STALLS > 1);

    state_t                   state;
    state_t                   state_next;
    logic [NB_STALL_CNT-1:0]  rem;
    logic [NB_STALL_CNT-1:0]  rem_next;
    logic [NB_PERF_CNT-1:0]   stall_cnt;

    logic                     pc_we;
    logic                     ifid_we;
    logic                     ifid_flush;
    logic                     idex_bubble;
    logic                     hazard_freeze;

    // Next-state and control decode. While i_valid is low everything holds
    // and all enables stay low, so a debug pause never loses a pending freeze.
    always_comb begin
        state_next    = state;
        rem_next      = rem;
        pc_we         = 1'b0;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        hazard_freeze = 1'b0;

        if (i_valid) begin
            case (state)
                RUN: begin
                    if (i_hazard) begin
                        idex_bubble   = 1'b1;
                        hazard_freeze = 1'b1;
                        if (i_hazard_ld_br && MULTI_CYCLE_LD_BR) begin
                            state_next = STALL;
                            rem_next   = REM_LOAD;
                        end
                    end else if (i_halt) begin
                        idex_bubble = 1'b1;
                        state_next  = HALTED;
                    end else begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = i_branch_taken & FLUSH_ON_BRANCH;
                    end
                end

                STALL: begin
                    idex_bubble   = 1'b1;
                    hazard_freeze = 1'b1;
                    // A rem of zero cannot occur here; it is treated as the last cycle.
                    if (rem <= REM_ONE) begin
                        state_next = RUN;
                        rem_next   = '0;
                    end else begin
                        rem_next = rem - REM_ONE;
                    end
                end

                HALTED: begin
                    idex_bubble = 1'b1;
                end

                default: begin
                    state_next = RUN;
                    rem_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt <= '0;
        end else if (hazard_freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + NB_PERF_CNT'(1);
        end
    end

    // Reset forces a bubble so that no half-decoded instruction enters EX.
    assign o_pc_we        = ~i_reset & pc_we;
    assign o_ifid_we      = ~i_reset & ifid_we;
    assign o_ifid_flush   = ~i_reset & ifid_flush;
    assign o_idex_bubble  = i_reset | idex_bubble;
    assign o_halted       = ~i_reset & (state == HALTED);
    assign o_stall_cycles = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl: a directed vector table on a default
// instance, and hand sequences on an LD_BR_STALLS=3 / 4-bit counter instance.
`default_nettype none

module tb_pipeline_stall_ctrl;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic FL = 1'b0;
`else
    localparam logic FL = 1'b1;
`endif

    typedef struct packed {
        logic [4:0]  ins;   // {valid, hazard, ld_br, branch_taken, halt}
        logic [4:0]  outs;  // {pc_we, ifid_we, flush, bubble, halted}
        logic [31:0] cnt;   // stall_cycles seen before the clock edge
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_valid, a_hazard, a_ld_br, a_br, a_halt;
    logic a_pc_we, a_ifid_we, a_flush, a_bubble, a_halted;
    logic [31:0] a_cnt;

    logic b_rst, b_valid, b_hazard, b_ld_br, b_br, b_halt;
    logic b_pc_we, b_ifid_we, b_flush, b_bubble, b_halted;
    logic [3:0] b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_stall_ctrl dut_a (
        .i_clock        (clk),
        .i_reset        (a_rst),
        .i_valid        (a_valid),
        .i_hazard       (a_hazard),
        .i_hazard_ld_br (a_ld_br),
        .i_branch_taken (a_br),
        .i_halt         (a_halt),
        .o_pc_we        (a_pc_we),
        .o_ifid_we      (a_ifid_we),
        .o_ifid_flush   (a_flush),
        .o_idex_bubble  (a_bubble),
        .o_halted       (a_halted),
        .o_stall_cycles (a_cnt)
    );

    pipeline_stall_ctrl #(
        .LD_BR_STALLS (3),
        .NB_STALL_CNT (2),
        .NB_PERF_CNT  (4)
    ) dut_b (
        .i_clock        (clk),
        .i_reset        (b_rst),
        .i_valid        (b_valid),
        .i_hazard       (b_hazard),
        .i_hazard_ld_br (b_ld_br),
        .i_branch_taken (b_br),
        .i_halt         (b_halt),
        .o_pc_we        (b_pc_we),
        .o_ifid_we      (b_ifid_we),
        .o_ifid_flush   (b_flush),
        .o_idex_bubble  (b_bubble),
        .o_halted       (b_halted),
        .o_stall_cycles (b_cnt)
    );

    function automatic vec_t mk(input logic [4:0] ins, input logic [4:0] outs, input int cnt);
        vec_t v;
        v.ins  = ins;
        v.outs = outs;
        v.cnt  = 32'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit sel, input vec_t v);
        logic [4:0]  o;
        logic [31:0] c;
        if (sel) begin
            o = {b_pc_we, b_ifid_we, b_flush, b_bubble, b_halted};
            c = {28'd0, b_cnt};
        end else begin
            o = {a_pc_we, a_ifid_we, a_flush, a_bubble, a_halted};
            c = a_cnt;
        end
        chk({tag, " pc_we"},        32'(o[4]), 32'(v.outs[4]));
        chk({tag, " ifid_we"},      32'(o[3]), 32'(v.outs[3]));
        chk({tag, " ifid_flush"},   32'(o[2]), 32'(v.outs[2]));
        chk({tag, " idex_bubble"},  32'(o[1]), 32'(v.outs[1]));
        chk({tag, " halted"},       32'(o[0]), 32'(v.outs[0]));
        chk({tag, " stall_cycles"}, c,         v.cnt);
    endtask

    // Drive one cycle of inputs at the falling edge (releasing reset) and
    // check the combinational outputs before the next rising edge.
    task automatic apply(input string tag, input bit sel, input vec_t v);
        @(negedge clk);
        if (sel) begin
            b_rst = 1'b0;
            {b_valid, b_hazard, b_ld_br, b_br, b_halt} = v.ins;
        end else begin
            a_rst = 1'b0;
            {a_valid, a_hazard, a_ld_br, a_br, a_halt} = v.ins;
        end
        #1;
        check_outs(tag, sel, v);
    endtask

    vec_t tbl [17];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = mk(5'b10000, 5'b11000, 0);
        tbl[1]  = mk(5'b11000, 5'b00010, 0);
        tbl[2]  = mk(5'b10000, 5'b11000, 1);
        tbl[3]  = mk(5'b11100, 5'b00010, 1);
        tbl[4]  = mk(5'b10000, 5'b00010, 2);
        tbl[5]  = mk(5'b10000, 5'b11000, 3);
        tbl[6]  = mk(5'b11010, 5'b00010, 3);
        tbl[7]  = mk(5'b10010, {2'b11, FL, 2'b00}, 4);
        tbl[8]  = mk(5'b10000, 5'b11000, 4);
        tbl[9]  = mk(5'b01111, 5'b00000, 4);
        tbl[10] = mk(5'b11100, 5'b00010, 4);
        tbl[11] = mk(5'b11111, 5'b00010, 5);
        tbl[12] = mk(5'b10100, 5'b11000, 6);
        tbl[13] = mk(5'b10011, 5'b00010, 6);
        tbl[14] = mk(5'b10000, 5'b00011, 6);
        tbl[15] = mk(5'b00000, 5'b00001, 6);
        tbl[16] = mk(5'b11010, 5'b00011, 6);

        a_rst = 1'b1; a_valid = 1'b1; a_hazard = 1'b0; a_ld_br = 1'b0; a_br = 1'b0; a_halt = 1'b0;
        b_rst = 1'b1; b_valid = 1'b0; b_hazard = 1'b0; b_ld_br = 1'b0; b_br = 1'b0; b_halt = 1'b0;

        // Reset held with i_valid=1
        @(negedge clk); #1;
        check_outs("reset", 1'b0, mk(5'b10000, 5'b00010, 0));
        @(negedge clk); #1;
        check_outs("reset2", 1'b0, mk(5'b10000, 5'b00010, 0));

        for (int i = 0; i < 17; i++)
            apply($sformatf("vec%0d", i), 1'b0, tbl[i]);

        for (int i = 0; i < 10; i++)
            apply($sformatf("halt_hold%0d", i), 1'b0, mk(5'b10000, 5'b00011, 6));

        // Only reset leaves HALTED
        @(negedge clk); a_rst = 1'b1; #1;
        check_outs("halt_reset", 1'b0, mk(5'b10000, 5'b00010, 0));
        apply("hazard_over_halt", 1'b0, mk(5'b11001, 5'b00010, 0));
        apply("after_hz_halt",    1'b0, mk(5'b10000, 5'b11000, 1));

        // Reset in the middle of a multi-cycle stall
        apply("ldbr_enter", 1'b0, mk(5'b11100, 5'b00010, 1));
        @(negedge clk);
        a_rst = 1'b1;
        {a_valid, a_hazard, a_ld_br, a_br, a_halt} = 5'b10000;
        #1;
        check_outs("mid_stall_reset", 1'b0, mk(5'b10000, 5'b00010, 0));
        apply("post_reset_run0", 1'b0, mk(5'b10000, 5'b11000, 0));
        apply("post_reset_run1", 1'b0, mk(5'b10000, 5'b11000, 0));

        // Instance B: three-cycle load->branch freeze paused by i_valid=0
        apply("b_ldbr",    1'b1, mk(5'b11100, 5'b00010, 0));
        for (int i = 0; i < 3; i++)
            apply($sformatf("b_pause%0d", i), 1'b1, mk(5'b01111, 5'b00000, 1));
        apply("b_stall1",  1'b1, mk(5'b10000, 5'b00010, 1));
        apply("b_stall2",  1'b1, mk(5'b10000, 5'b00010, 2));
        apply("b_run",     1'b1, mk(5'b10000, 5'b11000, 3));

        // Counter saturation at 4 bits
        for (int k = 0; k < 20; k++)
            apply($sformatf("b_sat%0d", k), 1'b1,
                  mk(5'b11000, 5'b00010, (3 + k > 15) ? 15 : 3 + k));
        apply("b_sat_end", 1'b1, mk(5'b10000, 5'b11000, 15));
        apply("b_branch",  1'b1, mk(5'b10010, {2'b11, FL, 2'b00}, 15));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
